pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_skid_reg_if.sv | 27 ++
 rtl/pipe_slot.sv | 57 +++++
 rtl/pipe_skid_reg.sv | 107 ++++++++++
 tb/tb_pipe_skid_reg.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared defaults, lane slicing helper and slot command encoding for the pipeline skid register.
// Consumers: pipe_skid_reg_if, pipe_slot, pipe_skid_reg and the testbench.
package pipe_pkg;

   localparam int unsigned DEFAULT_LANES = 2;
   localparam int unsigned DEFAULT_WIDTH = 128;

   typedef enum logic [1:0] {
      SLOT_HOLD,
      SLOT_LOAD,
      SLOT_CLEAR
   } slot_op_e;

   // Lane k of a bundle lives at bits [lane_lsb(k, width) +: width].
   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Upstream/downstream bundle handshake of the pipeline skid register.
// The slave modport is the register's view; master is the surrounding logic driving it.
interface pipe_skid_reg_if
   import pipe_pkg::*;
#(
   parameter int unsigned LANES = DEFAULT_LANES,
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);

   logic [LANES-1:0]       in_valid;
   logic [LANES*WIDTH-1:0] in_data;
   logic                   in_ready;
   logic [LANES-1:0]       out_valid;
   logic [LANES*WIDTH-1:0] out_data;
   logic                   out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/pipe_slot.sv
// One bundle holding slot: per-lane valid plus payload, commanded to hold, load or clear.
// Payload is zeroed whenever the slot ends up empty so no stale data is ever visible.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int unsigned LANES = DEFAULT_LANES,
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  slot_op_e               op,
   input  logic [LANES-1:0]       wr_valid,
   input  logic [LANES*WIDTH-1:0] wr_data,
   output logic [LANES-1:0]       valid,
   output logic [LANES*WIDTH-1:0] data
);

   logic [LANES-1:0]       valid_d, valid_q;
   logic [LANES*WIDTH-1:0] data_d, data_q;

   // Loading a bundle whose lane 0 is invalid is the same as clearing the slot.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      case (op)
         SLOT_LOAD: begin
            if (wr_valid[0]) begin
               valid_d = wr_valid;
               data_d  = wr_data;
            end else begin
               valid_d = '0;
               data_d  = '0;
            end
         end
         SLOT_CLEAR: begin
            valid_d = '0;
            data_d  = '0;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline register with 1-cycle latency, flush / exception flush and optional skid slot.
// Define PIPE_SKID_BUFFER_EN to add the skid slot and register in_ready; otherwise in_ready is combinational.
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int unsigned LANES = DEFAULT_LANES,
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            exception_flush,
   pipe_skid_reg_if.slave  bus,
   output logic [1:0]      occ
);

   logic [LANES-1:0]       m_valid;
   logic [LANES*WIDTH-1:0] m_data;
   logic [LANES-1:0]       m_wr_valid;
   logic [LANES*WIDTH-1:0] m_wr_data;
   slot_op_e               m_op;
   logic                   m_full;
   logic                   in_fire;
   logic                   out_fire;
   logic                   flush_all;

   assign m_full   = m_valid[0];
   assign in_fire  = bus.in_valid[0] & bus.in_ready;
   assign out_fire = m_full & bus.out_ready;

   // A plain flush must not yank a bundle the downstream has not taken yet.
   assign flush_all = exception_flush | (flush & (bus.out_ready | !m_full));

   pipe_slot #(.LANES(LANES), .WIDTH(WIDTH)) u_main (
      .clk      (clk),
      .rst      (rst),
      .op       (m_op),
      .wr_valid (m_wr_valid),
      .wr_data  (m_wr_data),
      .valid    (m_valid),
      .data     (m_data)
   );

   assign bus.out_valid = m_valid;
   assign bus.out_data  = m_data;

`ifdef PIPE_SKID_BUFFER_EN
   logic [LANES-1:0]       s_valid;
   logic [LANES*WIDTH-1:0] s_data;
   slot_op_e               s_op;
   logic                   s_full;

   assign s_full       = s_valid[0];
   assign bus.in_ready = !s_full;
   assign occ          = {1'b0, m_full} + {1'b0, s_full};

   // The skid slot always drains into main before new input; in_ready=0 while it is full.
   always_comb begin
      m_op       = SLOT_HOLD;
      m_wr_valid = bus.in_valid;
      m_wr_data  = bus.in_data;
      s_op       = SLOT_HOLD;
      if (flush_all) begin
         m_op = SLOT_CLEAR;
         s_op = SLOT_CLEAR;
      end else if (!m_full || out_fire) begin
         if (s_full) begin
            m_op       = SLOT_LOAD;
            m_wr_valid = s_valid;
            m_wr_data  = s_data;
            s_op       = SLOT_CLEAR;
         end else if (in_fire) begin
            m_op = SLOT_LOAD;
         end else begin
            m_op = SLOT_CLEAR;
         end
      end else if (in_fire) begin
         s_op = SLOT_LOAD;
      end
   end

   pipe_slot #(.LANES(LANES), .WIDTH(WIDTH)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .op       (s_op),
      .wr_valid (bus.in_valid),
      .wr_data  (bus.in_data),
      .valid    (s_valid),
      .data     (s_data)
   );
`else
   assign bus.in_ready = bus.out_ready | !m_full;
   assign occ          = {1'b0, m_full};

   always_comb begin
      m_op       = SLOT_HOLD;
      m_wr_valid = bus.in_valid;
      m_wr_data  = bus.in_data;
      if (flush_all) begin
         m_op = SLOT_CLEAR;
      end else if (!m_full || out_fire) begin
         m_op = in_fire ? SLOT_LOAD : SLOT_CLEAR;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: vector table, directed corner sequences and a queue scoreboard.
// Builds with or without PIPE_SKID_BUFFER_EN; expectations follow whichever build is compiled.
module tb_pipe_skid_reg;
   import pipe_pkg::*;

   localparam int unsigned LANES = DEFAULT_LANES;
   localparam int unsigned WIDTH = DEFAULT_WIDTH;
   localparam int unsigned DW    = LANES * WIDTH;

   typedef struct {
      string            name;
      logic [LANES-1:0] iv;
      logic [DW-1:0]    data;
      logic             fl;
      logic             xf;
      logic [LANES-1:0] exp_ov;
      logic [DW-1:0]    exp_od;
      logic [1:0]       exp_occ;
   } vec_t;

   typedef struct packed {
      logic [LANES-1:0] v;
      logic [DW-1:0]    d;
   } bundle_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       exception_flush;
   logic [1:0] occ;

   int n_checks = 0;
   int n_fail   = 0;

   vec_t    vecs[8];
   bundle_t sb_q[$];

   logic [DW-1:0] a_dat, b_dat, c_dat, d_dat, e_dat, f_dat;

   pipe_skid_reg_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

   pipe_skid_reg #(.LANES(LANES), .WIDTH(WIDTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .exception_flush (exception_flush),
      .bus             (bus),
      .occ             (occ)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] pattern(input logic [7:0] tag);
      logic [DW-1:0] r;
      r = '0;
      for (int unsigned k = 0; k < LANES; k++)
         r[lane_lsb(k, WIDTH) +: WIDTH] = {(WIDTH/8){tag + 8'(k)}};
      return r;
   endfunction

   function automatic logic [DW-1:0] random_data(input logic [LANES-1:0] iv);
      logic [DW-1:0] r;
      r = '0;
      for (int unsigned k = 0; k < LANES; k++)
         for (int unsigned w = 0; w < WIDTH/32; w++)
            if (iv[k]) r[lane_lsb(k, WIDTH) + 32*w +: 32] = $urandom;
      return r;
   endfunction

   function automatic vec_t make_vec(input string name, input logic [LANES-1:0] iv, input logic [DW-1:0] data,
                                     input logic fl, input logic xf, input logic [LANES-1:0] exp_ov,
                                     input logic [DW-1:0] exp_od, input logic [1:0] exp_occ);
      vec_t v;
      v.name = name; v.iv = iv; v.data = data; v.fl = fl; v.xf = xf;
      v.exp_ov = exp_ov; v.exp_od = exp_od; v.exp_occ = exp_occ;
      return v;
   endfunction

   task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [LANES-1:0] iv, input logic [DW-1:0] d, input logic ordy,
                                 input logic fl, input logic xf);
      bus.in_valid    = iv;
      bus.in_data     = d;
      bus.out_ready   = ordy;
      flush           = fl;
      exception_flush = xf;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic [LANES-1:0] ov, input logic [DW-1:0] od,
                              input logic [1:0] exp_occ);
      check_output({tag, " out_valid"}, DW'(bus.out_valid), DW'(ov));
      check_output({tag, " out_data"},  bus.out_data, od);
      check_output({tag, " occ"},       DW'(occ), DW'(exp_occ));
   endtask

   initial begin
      a_dat = pattern(8'hA0);
      b_dat = pattern(8'hB0);
      c_dat = pattern(8'hC0);
      e_dat = pattern(8'hE0);
      f_dat = pattern(8'hF0);
      d_dat = pattern(8'hD0);
      d_dat[DW-1:WIDTH] = '0;

      vecs[0] = make_vec("full A",     2'b11, a_dat, 1'b0, 1'b0, 2'b11, a_dat, 2'd1);
      vecs[1] = make_vec("lane0 D",    2'b01, d_dat, 1'b0, 1'b0, 2'b01, d_dat, 2'd1);
      vecs[2] = make_vec("idle",       2'b00, '0,    1'b0, 1'b0, 2'b00, '0,    2'd0);
      vecs[3] = make_vec("full B",     2'b11, b_dat, 1'b0, 1'b0, 2'b11, b_dat, 2'd1);
      vecs[4] = make_vec("flush C",    2'b11, c_dat, 1'b1, 1'b0, 2'b00, '0,    2'd0);
      vecs[5] = make_vec("full E",     2'b11, e_dat, 1'b0, 1'b0, 2'b11, e_dat, 2'd1);
      vecs[6] = make_vec("exflush F",  2'b11, f_dat, 1'b0, 1'b1, 2'b00, '0,    2'd0);
      vecs[7] = make_vec("idle end",   2'b00, '0,    1'b0, 1'b0, 2'b00, '0,    2'd0);

      rst = 1'b0;
      apply_stimulus(2'b00, '0, 1'b0, 1'b0, 1'b0);
      #12;
      check_state("reset", 2'b00, '0, 2'd0);
      check_output("reset in_ready", DW'(bus.in_ready), DW'(1'b1));
      #6 rst = 1'b1;
      tick();
      check_output("post-reset in_ready", DW'(bus.in_ready), DW'(1'b1));

      // Streaming with out_ready=1: each bundle appears one edge after it is offered.
      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].iv, vecs[i].data, 1'b1, vecs[i].fl, vecs[i].xf);
         tick();
         check_state(vecs[i].name, vecs[i].exp_ov, vecs[i].exp_od, vecs[i].exp_occ);
         check_output({vecs[i].name, " in_ready"}, DW'(bus.in_ready), DW'(1'b1));
      end

      $display("[TB] backpressure sequence");
      apply_stimulus(2'b11, a_dat, 1'b0, 1'b0, 1'b0);
      #1 check_output("bp in_ready empty", DW'(bus.in_ready), DW'(1'b1));
      tick();
      check_state("bp A held", 2'b11, a_dat, 2'd1);
`ifdef PIPE_SKID_BUFFER_EN
      check_output("bp in_ready M full", DW'(bus.in_ready), DW'(1'b1));
      apply_stimulus(2'b11, b_dat, 1'b0, 1'b0, 1'b0);
      tick();
      check_state("bp A+B", 2'b11, a_dat, 2'd2);
      check_output("bp in_ready skid full", DW'(bus.in_ready), DW'(1'b0));
      apply_stimulus(2'b00, '0, 1'b1, 1'b0, 1'b0);
      #1 check_output("bp in_ready registered", DW'(bus.in_ready), DW'(1'b0));
      tick();
      check_state("bp B out", 2'b11, b_dat, 2'd1);
      check_output("bp in_ready back", DW'(bus.in_ready), DW'(1'b1));
`else
      check_output("bp in_ready M full", DW'(bus.in_ready), DW'(1'b0));
      apply_stimulus(2'b11, b_dat, 1'b0, 1'b0, 1'b0);
      tick();
      check_state("bp B refused", 2'b11, a_dat, 2'd1);
      apply_stimulus(2'b11, b_dat, 1'b1, 1'b0, 1'b0);
      #1 check_output("bp in_ready follows out_ready", DW'(bus.in_ready), DW'(1'b1));
      tick();
      check_state("bp B out", 2'b11, b_dat, 2'd1);
      apply_stimulus(2'b00, '0, 1'b1, 1'b0, 1'b0);
`endif
      tick();
      check_state("bp drained", 2'b00, '0, 2'd0);

      $display("[TB] flush sequence");
      apply_stimulus(2'b11, a_dat, 1'b1, 1'b0, 1'b0);
      tick();
      apply_stimulus(2'b00, '0, 1'b0, 1'b1, 1'b0);
      tick();
      check_state("flush ignored", 2'b11, a_dat, 2'd1);
      apply_stimulus(2'b11, c_dat, 1'b1, 1'b1, 1'b0);
      tick();
      check_state("flush honoured", 2'b00, '0, 2'd0);
      apply_stimulus(2'b00, '0, 1'b1, 1'b0, 1'b0);
      tick();
      check_state("flush C dropped", 2'b00, '0, 2'd0);

      $display("[TB] exception flush sequence");
      apply_stimulus(2'b11, a_dat, 1'b0, 1'b0, 1'b0);
      tick();
      apply_stimulus(2'b11, b_dat, 1'b0, 1'b0, 1'b0);
      tick();
`ifdef PIPE_SKID_BUFFER_EN
      check_output("exflush occ before", DW'(occ), DW'(2'd2));
`else
      check_output("exflush occ before", DW'(occ), DW'(2'd1));
`endif
      apply_stimulus(2'b00, '0, 1'b0, 1'b0, 1'b1);
      tick();
      check_state("exflush", 2'b00, '0, 2'd0);
      check_output("exflush in_ready", DW'(bus.in_ready), DW'(1'b1));

      $display("[TB] async reset sequence");
      apply_stimulus(2'b11, a_dat, 1'b0, 1'b0, 1'b0);
      tick();
      apply_stimulus(2'b11, b_dat, 1'b0, 1'b0, 1'b0);
      tick();
      apply_stimulus(2'b00, '0, 1'b0, 1'b0, 1'b0);
      check_output("areset occ before", DW'(occ == 2'd0), DW'(1'b0));
      #3 rst = 1'b0;
      #1;
      check_state("areset", 2'b00, '0, 2'd0);
      check_output("areset in_ready", DW'(bus.in_ready), DW'(1'b1));
      #2 rst = 1'b1;
      tick();
      check_state("areset release", 2'b00, '0, 2'd0);

      $display("[TB] scoreboard phase");
      for (int cyc = 0; cyc < 300; cyc++) begin
         logic [LANES-1:0] iv;
         logic [DW-1:0]    d;
         logic             ordy, fl, xf, exp_ir, clr;
         int               held;
         case ($urandom_range(0, 2))
            0:       iv = 2'b00;
            1:       iv = 2'b01;
            default: iv = 2'b11;
         endcase
         d    = random_data(iv);
         ordy = ($urandom_range(0, 1) == 1);
         fl   = ($urandom_range(0, 15) == 0);
         xf   = ($urandom_range(0, 31) == 0);
         apply_stimulus(iv, d, ordy, fl, xf);
         #1;
         held = sb_q.size();
`ifdef PIPE_SKID_BUFFER_EN
         exp_ir = (held < 2);
`else
         exp_ir = ordy || (held == 0);
`endif
         check_output("sb in_ready", DW'(bus.in_ready), DW'(exp_ir));
         check_output("sb occ", DW'(occ), DW'(held));
         if (held > 0) begin
            check_output("sb out_valid", DW'(bus.out_valid), DW'(sb_q[0].v));
            check_output("sb out_data", bus.out_data, sb_q[0].d);
         end else begin
            check_output("sb out_valid idle", DW'(bus.out_valid), '0);
            check_output("sb out_data idle", bus.out_data, '0);
         end
         clr = xf || (fl && (ordy || held == 0));
         if (clr) begin
            sb_q.delete();
         end else begin
            if (held > 0 && ordy) void'(sb_q.pop_front());
            if (iv[0] && exp_ir) sb_q.push_back({iv, d});
         end
         tick();
      end
      check_output("sb final occ", DW'(occ), DW'(sb_q.size()));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
